// File: rtl/sliced_alu_pkg.sv
// sliced_alu_pkg: shared types and constants for the bit-serial-by-slice ALU.
// Holds the FSM state enum, common 74181 select encodings and mode constants.
package sliced_alu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // S_SUB and S_XOR share a code; the M input picks the meaning
    localparam logic [3:0] S_ADD   = 4'b1001;
    localparam logic [3:0] S_SUB   = 4'b0110;
    localparam logic [3:0] S_XOR   = 4'b0110;
    localparam logic [3:0] S_AND   = 4'b1011;
    localparam logic [3:0] S_OR    = 4'b1110;
    localparam logic [3:0] S_PASSA = 4'b1111;

    localparam logic M_LOGIC = 1'b1;
    localparam logic M_ARITH = 1'b0;

endpackage

// File: rtl/alu_slice.sv
// alu_slice: combinational W-bit 74181-style function unit (active-high data).
// Ports: a, b, s, m, cin in; f, cout out; cin_msb out with SLICED_ALU_OVERFLOW_EN.
module alu_slice
    import sliced_alu_pkg::*;
#(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [3:0]   s,
    input  logic         m,
    input  logic         cin,
`ifdef SLICED_ALU_OVERFLOW_EN
    output logic         cin_msb,
`endif
    output logic [W-1:0] f,
    output logic         cout
);

    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [W:0]   sum;
    logic [W-1:0] low;

    // 74181 operand terms: arithmetic result is x + y + cin,
    // and the logic result is the bitwise xnor of the same terms.
    assign x = a | (b & {W{s[0]}}) | (~b & {W{s[1]}});
    assign y = (a & ~b & {W{s[2]}}) | (a & b & {W{s[3]}});

    assign sum = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, cin};
    // Sum of the lower W-1 bits; its top bit is the carry into the slice MSB
    assign low = {1'b0, x[W-2:0]} + {1'b0, y[W-2:0]} + {{(W-1){1'b0}}, cin};

    assign f    = m ? ~(x ^ y) : sum[W-1:0];
    assign cout = m ? 1'b0 : sum[W];

`ifdef SLICED_ALU_OVERFLOW_EN
    assign cin_msb = m ? 1'b0 : low[W-1];
`else
    logic unused_low;
    assign unused_low = ^low;
`endif

endmodule

// File: rtl/sliced_alu.sv
// sliced_alu: WIDTH-bit 74181-function ALU computed SLICE bits per clock, LSB first.
// Ports: clk, rst_n, start, A, B, S, M, Pin in; busy, done, R, Pout, Z out;
// V (signed overflow) out only when SLICED_ALU_OVERFLOW_EN is defined.
module sliced_alu
    import sliced_alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       S,
    input  logic             M,
    input  logic             Pin,
`ifdef SLICED_ALU_OVERFLOW_EN
    output logic             V,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] R,
    output logic             Pout,
    output logic             Z
);

    localparam int NSL = WIDTH / SLICE;
    localparam int CW  = (NSL > 1) ? $clog2(NSL) : 1;

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] shadow;
    logic [3:0]       s_q;
    logic             m_q;
    logic             carry_q;
    logic [CW-1:0]    cnt;

    logic [SLICE-1:0] f_sl;
    logic             cout_sl;

`ifdef SLICED_ALU_OVERFLOW_EN
    logic cmsb_sl;
    logic cmsb_q;
`endif

    // Operands shift right each RUN cycle so the active slice is always
    // the low SLICE bits; results enter the shadow from the top.
    alu_slice #(
        .W (SLICE)
    ) u_slice (
        .a       (a_q[SLICE-1:0]),
        .b       (b_q[SLICE-1:0]),
        .s       (s_q),
        .m       (m_q),
        .cin     (carry_q),
`ifdef SLICED_ALU_OVERFLOW_EN
        .cin_msb (cmsb_sl),
`endif
        .f       (f_sl),
        .cout    (cout_sl)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            shadow  <= '0;
            s_q     <= '0;
            m_q     <= 1'b0;
            carry_q <= 1'b0;
            cnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            R       <= '0;
            Pout    <= 1'b0;
            Z       <= 1'b0;
`ifdef SLICED_ALU_OVERFLOW_EN
            cmsb_q  <= 1'b0;
            V       <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        a_q     <= A;
                        b_q     <= B;
                        s_q     <= S;
                        m_q     <= M;
                        carry_q <= Pin;
                        cnt     <= '0;
                        busy    <= 1'b1;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    a_q     <= a_q >> SLICE;
                    b_q     <= b_q >> SLICE;
                    shadow  <= (shadow >> SLICE)
                             | (WIDTH'(f_sl) << (WIDTH - SLICE));
                    carry_q <= cout_sl;
                    if (cnt == CW'(NSL - 1)) begin
`ifdef SLICED_ALU_OVERFLOW_EN
                        cmsb_q <= cmsb_sl;
`endif
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    R     <= shadow;
                    Pout  <= carry_q & ~m_q;
                    Z     <= (shadow == '0);
`ifdef SLICED_ALU_OVERFLOW_EN
                    V     <= (cmsb_q ^ carry_q) & ~m_q;
`endif
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sliced_alu.sv
// tb_sliced_alu: directed self-checking bench for sliced_alu (16-bit, 4-bit slices).
// Covers reset, add/sub/logic functions, latency, busy handling and mid-op reset.
module tb_sliced_alu;
    import sliced_alu_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] A;
    logic [15:0] B;
    logic [3:0]  S;
    logic        M;
    logic        Pin;
    logic        busy;
    logic        done;
    logic [15:0] R;
    logic        Pout;
    logic        Z;
`ifdef SLICED_ALU_OVERFLOW_EN
    logic        V;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    sliced_alu #(
        .WIDTH (16),
        .SLICE (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (A),
        .B     (B),
        .S     (S),
        .M     (M),
        .Pin   (Pin),
`ifdef SLICED_ALU_OVERFLOW_EN
        .V     (V),
`endif
        .busy  (busy),
        .done  (done),
        .R     (R),
        .Pout  (Pout),
        .Z     (Z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one operation, check busy, R hold during RUN, latency and results
    task automatic op(input string tag, input logic [15:0] a,
                      input logic [15:0] b, input logic [3:0] s,
                      input logic m, input logic pin,
                      input logic [15:0] hold, input logic [15:0] er,
                      input logic ep, input logic ez);
        int lat;
        @(negedge clk);
        A = a; B = b; S = s; M = m; Pin = pin; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            lat++;
            if (lat == 2) chk({tag, "_hold"}, 32'(R), 32'(hold));
            if (done) break;
        end
        chk({tag, "_lat"}, 32'(lat), 32'd5);
        chk({tag, "_R"}, 32'(R), 32'(er));
        chk({tag, "_P"}, 32'(Pout), 32'(ep));
        chk({tag, "_Z"}, 32'(Z), 32'(ez));
        chk({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int nd;
        int first;
        int second;
        rst_n = 1'b0;
        start = 1'b0;
        A = '0; B = '0; S = '0; M = 1'b0; Pin = 1'b0;
        nd = 0; first = -1; second = -1;

        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_R", 32'(R), 32'd0);
        chk("rst_P", 32'(Pout), 32'd0);
        chk("rst_Z", 32'(Z), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        op("add", 16'h00FF, 16'h0001, S_ADD, M_ARITH, 1'b0,
           16'h0000, 16'h0100, 1'b0, 1'b0);
        op("sub0", 16'h1234, 16'h1234, S_SUB, M_ARITH, 1'b1,
           16'h0100, 16'h0000, 1'b1, 1'b1);
        op("xor", 16'hF0F0, 16'hFF00, S_XOR, M_LOGIC, 1'b1,
           16'h0000, 16'h0FF0, 1'b0, 1'b0);
        op("and", 16'hF0F0, 16'hFF00, S_AND, M_LOGIC, 1'b1,
           16'h0FF0, 16'hF000, 1'b0, 1'b0);
        op("or", 16'hF0F0, 16'hFF00, S_OR, M_LOGIC, 1'b0,
           16'hF000, 16'hFFF0, 1'b0, 1'b0);
        op("passa", 16'hABCD, 16'h1234, S_PASSA, M_LOGIC, 1'b0,
           16'hFFF0, 16'hABCD, 1'b0, 1'b0);
        op("zeros", 16'hABCD, 16'h1234, 4'b0011, M_LOGIC, 1'b1,
           16'hABCD, 16'h0000, 1'b0, 1'b1);
        op("ones", 16'hABCD, 16'h1234, 4'b1100, M_LOGIC, 1'b0,
           16'h0000, 16'hFFFF, 1'b0, 1'b0);
        op("dec0", 16'h0000, 16'h5555, 4'b1111, M_ARITH, 1'b0,
           16'hFFFF, 16'hFFFF, 1'b0, 1'b0);
        op("dec5", 16'h0005, 16'h5555, 4'b1111, M_ARITH, 1'b0,
           16'hFFFF, 16'h0004, 1'b1, 1'b0);
        op("addc", 16'hFFFF, 16'h0000, S_ADD, M_ARITH, 1'b1,
           16'h0004, 16'h0000, 1'b1, 1'b1);
        op("dbl", 16'h8421, 16'h0000, 4'b1100, M_ARITH, 1'b0,
           16'h0000, 16'h0842, 1'b1, 1'b0);
        op("amb1", 16'h0005, 16'h0003, S_SUB, M_ARITH, 1'b0,
           16'h0842, 16'h0001, 1'b1, 1'b0);

        // start held for 10 cycles; A disturbed only during the first RUN
        @(negedge clk);
        A = 16'h0001; B = 16'h0001; S = S_ADD; M = M_ARITH; Pin = 1'b0;
        start = 1'b1;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (k == 2) A = 16'h00FF;
            if (k == 4) A = 16'h0001;
            if (k == 9) start = 1'b0;
            if (done) begin
                chk("bb_R", 32'(R), 32'h0002);
                if (nd == 0) first = k;
                else second = k;
                nd++;
            end
        end
        chk("bb_count", 32'(nd), 32'd2);
        chk("bb_first", 32'(first), 32'd5);
        chk("bb_second", 32'(second), 32'd11);

        // reset two cycles into an operation
        @(negedge clk);
        A = 16'h00FF; B = 16'h0001; S = S_ADD; M = M_ARITH; Pin = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mr_busy", 32'(busy), 32'd0);
        chk("mr_R", 32'(R), 32'd0);
        chk("mr_done", 32'(done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        nd = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (done) nd++;
        end
        chk("mr_nodone", 32'(nd), 32'd0);
        op("fresh", 16'h00FF, 16'h0001, S_ADD, M_ARITH, 1'b0,
           16'h0000, 16'h0100, 1'b0, 1'b0);

`ifdef SLICED_ALU_OVERFLOW_EN
        op("ovf", 16'h7FFF, 16'h0001, S_ADD, M_ARITH, 1'b0,
           16'h0100, 16'h8000, 1'b0, 1'b0);
        chk("ovf_V", 32'(V), 32'd1);
        op("ovlog", 16'hF0F0, 16'hFF00, S_XOR, M_LOGIC, 1'b0,
           16'h8000, 16'h0FF0, 1'b0, 1'b0);
        chk("ovlog_V", 32'(V), 32'd0);
        op("wrap", 16'hFFFF, 16'h0001, S_ADD, M_ARITH, 1'b0,
           16'h0FF0, 16'h0000, 1'b1, 1'b1);
        chk("wrap_V", 32'(V), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
